// File: rtl/mux2to1.sv
// 2:1 select in three equivalent forms (conditional, if/else, case) with a sticky cross-check flag.
// Define MUX2TO1_REG_OUT_EN to register out_reg; otherwise out_reg follows out_case combinationally.
module mux2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out_cond,
  output logic [WIDTH-1:0] out_if,
  output logic [WIDTH-1:0] out_case,
  output logic [WIDTH-1:0] out_reg,
  output logic             mismatch
);

  logic [WIDTH-1:0] if_sel;
  logic [WIDTH-1:0] case_sel;

  assign out_cond = sel ? in1 : in0;

  always_comb begin
    if (sel) if_sel = in1;
    else     if_sel = in0;
  end

  // default arm keeps the output driven for non-0/1 sel
  always_comb begin
    case (sel)
      1'b0:    case_sel = in0;
      1'b1:    case_sel = in1;
      default: case_sel = in0;
    endcase
  end

  // continuous drivers so the ports can be overridden and restored cleanly
  assign out_if   = if_sel;
  assign out_case = case_sel;

  // != on purpose: an X-only difference evaluates unknown and leaves the flag alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mismatch <= 1'b0;
    else if ((out_cond != out_if) || (out_if != out_case))
      mismatch <= 1'b1;
  end

`ifdef MUX2TO1_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_reg <= '0;
    else     out_reg <= out_case;
  end
`else
  assign out_reg = out_case;
`endif

endmodule

// File: tb/tb_mux2to1.sv
// Randomised and directed checks of mux2to1 at WIDTH=1 and WIDTH=8 against a mask-based model.
module tb_mux2to1;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a0, a1, s;
  logic       c1_cond, c1_if, c1_case, c1_reg, c1_mm;
  logic [7:0] b0, b1;
  logic       t;
  logic [7:0] c8_cond, c8_if, c8_case, c8_reg;
  logic       c8_mm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in0(a0), .in1(a1), .sel(s),
    .out_cond(c1_cond), .out_if(c1_if), .out_case(c1_case),
    .out_reg(c1_reg), .mismatch(c1_mm)
  );

  mux2to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in0(b0), .in1(b1), .sel(t),
    .out_cond(c8_cond), .out_if(c8_if), .out_case(c8_case),
    .out_reg(c8_reg), .mismatch(c8_mm)
  );

`ifdef MUX2TO1_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  // model: each bit picks from in1 where the select mask is set, else from in0
  function automatic logic [7:0] pick8(input logic [7:0] x0, input logic [7:0] x1, input logic sl);
    logic [7:0] m;
    m = {8{sl}};
    return (x0 & ~m) | (x1 & m);
  endfunction

  task automatic test_reset();
    a0 = 1'b1; a1 = 1'b0; s = 1'b0;
    b0 = 8'h5A; b1 = 8'hC3; t = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL reset_mismatch got=%b want=0", c8_mm); end
    checks++; if (c1_mm !== 1'b0) begin errors++; $display("FAIL reset_mismatch1 got=%b want=0", c1_mm); end
    checks++; if (c8_reg !== (REG_OUT ? 8'h00 : 8'hC3)) begin errors++; $display("FAIL reset_out_reg got=%h want=%h", c8_reg, REG_OUT ? 8'h00 : 8'hC3); end
    checks++; if (c8_case !== 8'hC3) begin errors++; $display("FAIL reset_comb got=%h want=c3", c8_case); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    logic       e;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a0 = v[2]; a1 = v[1]; s = v[0];
      #50;
      e = pick8({7'd0, a0}, {7'd0, a1}, s) != 8'd0;
      checks++;
      if ({c1_cond, c1_if, c1_case} !== {3{e}}) begin
        errors++; $display("FAIL truth_%b got=%b%b%b want=%b", v, c1_cond, c1_if, c1_case, e);
      end
    end
    checks++; if (c1_mm !== 1'b0) begin errors++; $display("FAIL truth_mismatch got=%b want=0", c1_mm); end
  endtask

  task automatic test_wide();
    @(negedge clk);
    b0 = 8'hA5; b1 = 8'h3C; t = 1'b0;
    @(posedge clk); #1;
    checks++; if ({c8_cond, c8_if, c8_case, c8_reg} !== {4{8'hA5}}) begin errors++; $display("FAIL wide_sel0 got=%h %h %h %h want=a5", c8_cond, c8_if, c8_case, c8_reg); end
    @(negedge clk) t = 1'b1;
    @(posedge clk); #1;
    checks++; if ({c8_cond, c8_if, c8_case, c8_reg} !== {4{8'h3C}}) begin errors++; $display("FAIL wide_sel1 got=%h %h %h %h want=3c", c8_cond, c8_if, c8_case, c8_reg); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b0 = 8'($urandom); b1 = 8'($urandom); t = 1'($urandom);
      e = pick8(b0, b1, t);
      #1;
      checks++;
      if ({c8_cond, c8_if, c8_case} !== {3{e}}) begin
        errors++; $display("FAIL rand_comb_%0d got=%h %h %h want=%h", i, c8_cond, c8_if, c8_case, e);
      end
      if (!REG_OUT) begin
        checks++; if (c8_reg !== e) begin errors++; $display("FAIL rand_reg_nodelay_%0d got=%h want=%h", i, c8_reg, e); end
      end
      @(posedge clk); #1;
      checks++; if (c8_reg !== e) begin errors++; $display("FAIL rand_reg_%0d got=%h want=%h", i, c8_reg, e); end
    end
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL rand_mismatch got=%b want=0", c8_mm); end
  endtask

  task automatic test_reg_path();
    @(negedge clk);
    b0 = 8'h00; b1 = 8'h01; t = 1'b0;
    @(posedge clk); #1;
    t = 1'b1;
    #1;
    checks++; if (c8_case !== 8'h01) begin errors++; $display("FAIL regpath_case got=%h want=01", c8_case); end
    checks++; if (c8_reg !== (REG_OUT ? 8'h00 : 8'h01)) begin errors++; $display("FAIL regpath_before_edge got=%h want=%h", c8_reg, REG_OUT ? 8'h00 : 8'h01); end
    @(posedge clk); #1;
    checks++; if (c8_reg !== 8'h01) begin errors++; $display("FAIL regpath_after_edge got=%h want=01", c8_reg); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (c8_reg !== (REG_OUT ? 8'h00 : 8'h01)) begin errors++; $display("FAIL areset_out_reg got=%h want=%h", c8_reg, REG_OUT ? 8'h00 : 8'h01); end
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL areset_mismatch got=%b want=0", c8_mm); end
    checks++; if ({c8_cond, c8_if, c8_case} !== {3{8'h01}}) begin errors++; $display("FAIL areset_comb got=%h %h %h want=01", c8_cond, c8_if, c8_case); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (c8_reg !== 8'h01) begin errors++; $display("FAIL areset_reload got=%h want=01", c8_reg); end
  endtask

  task automatic test_mismatch_sticky();
    logic [7:0] e;
    @(negedge clk);
    b0 = 8'h96; b1 = 8'h0F; t = 1'b0;
    e = pick8(b0, b1, t);
    #1;
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL sticky_pre got=%b want=0", c8_mm); end
    force dut8.out_if = ~e;
    @(posedge clk); #1;
    checks++; if (c8_mm !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b want=1", c8_mm); end
    release dut8.out_if;
    @(negedge clk);
    checks++; if (c8_if !== e) begin errors++; $display("FAIL sticky_release got=%h want=%h", c8_if, e); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (c8_mm !== 1'b1) begin errors++; $display("FAIL sticky_hold got=%b want=1", c8_mm); end
    checks++; if (c1_mm !== 1'b0) begin errors++; $display("FAIL sticky_other got=%b want=0", c1_mm); end
    #2 rst = 1'b1;
    #1;
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b want=0", c8_mm); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (c8_mm !== 1'b0) begin errors++; $display("FAIL sticky_after_rst got=%b want=0", c8_mm); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_wide();
    test_random();
    test_reg_path();
    test_async_reset();
    test_mismatch_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
